ra_rd_ecc_sdr: RTL and testbench
================================

// Module: ra_rd_ecc_sdr
// PURPOSE
//  Read-side stage downstream of one 64x72 2R1W array read port. Tracks issued reads across the array
//  read latency, SECDED-checks each 72b word (64 data + 8 check), corrects single-bit errors and flags
//  double-bit errors. Keeps error counters and a first-error log for config/BIST readout.
//  One instance per read port.
// PARAMETERS
//  RD_LAT  1  cycles from rd_enb sampled to array rd_dat valid (1..3)
//  CNT_W   16 width of saturating error counters
// PORTS
//  clk      in  1     array clock
//  reset    in  1     synchronous, active-high
//  ecc_en   in  1     cfg bit; 0 = pass-through, no check/count
//  rd_enb   in  1     read issued to array this cycle
//  rd_adr   in  6     address of issued read
//  rd_dat   in  72    array read data [0:63] data, [64:71] check
//  out_val  out 1     corrected word valid
//  out_dat  out 64    corrected data
//  out_ce   out 1     single-bit error corrected (qualified by out_val)
//  out_ue   out 1     uncorrectable error (qualified by out_val)
//  err_clr  in  1     clear counters and error log
//  ce_cnt   out CNT_W saturating CE count
//  ue_cnt   out CNT_W saturating UE count
//  err_vld  out 1     error log holds an entry
//  err_adr  out 6     logged address
//  err_syn  out 8     logged syndrome
//  scr_req/scr_adr[6]/scr_dat[72] out, scr_ack in; wr_enb/wr_adr[6] in (snoop)  -- RA_ECC_SCRUB_EN only
// BEHAVIOUR
//  - Reset: out_val/out_ce/out_ue=0, out_dat=0, counters=0, err_vld=0, err_adr/err_syn=0; all in-flight
//    reads in the valid pipe discarded (no output for reads issued before or during reset).
//  - Valid pipe: {rd_enb,rd_adr} delayed RD_LAT cycles; data sampled at that cycle. Syndrome/correct
//    computed combinationally and registered: out_val asserts exactly RD_LAT+1 cycles after rd_enb.
//    Back-to-back reads every cycle supported, no stalls, no backpressure.
//  - Syndrome = recomputed check XOR rd_dat[64:71], Hsiao (72,64) odd-weight-column H matrix.
//    syn==0: clean. syn matches an H column: flip that bit, out_ce=1 (check-bit hit: data unchanged,
//    still CE). Any other nonzero syn: out_ue=1, out_dat = raw data.
//  - ecc_en=0: out_dat = rd_dat[0:63], out_ce=out_ue=0, no counting/logging. ecc_en sampled with data.
//  - Counters: +1 per CE/UE, saturate at all-ones (no wrap). err_clr same cycle as event: clear, then
//    event counted (counter=1).
//  - Log: first error captured, err_vld sticky. A UE overwrites a held CE entry once; later errors
//    ignored. err_clr with simultaneous error: log holds the new error.
// CONFIGURATION
//  RA_ECC_SCRUB_EN defined: 2-state FSM IDLE/REQ. IDLE + CE -> REQ, scr_adr=adr, scr_dat=corrected
//   word with regenerated check bits. REQ holds scr_req/adr/dat stable until scr_ack -> IDLE.
//   CEs while in REQ are counted, not scrubbed. Snooped wr_enb with wr_adr==scr_adr while in REQ
//   (without ack) cancels -> IDLE, scr_req drops next cycle. Reset -> IDLE, scr_req=0.
//  Not defined: no FSM, scrub/snoop ports absent; correction output only.
// STRUCTURE
//  Shared include ra_ecc_defs.vh: H-matrix column constants, data/check widths, syndrome width,
//   check-gen function (reused by the write-side encoder).
//  Sub-module ra_ecc_dec: combinational 72b -> {syn, corrected data, ce, ue}; top = pipe, counters,
//   log, scrub FSM.
// TESTING
//  1 RD_LAT=1, ecc_en=1, clean word adr 5 -> out_val 2 cycles after rd_enb, ce=ue=0, counts 0.
//  2 flip rd_dat[17], adr 9 -> data bit 17 corrected, out_ce=1, ce_cnt=1, err_vld=1, err_adr=9.
//  3 flip bits 3,40 adr 12 after test 2 -> out_ue=1, ue_cnt=1, err_adr=12 (UE overwrite); later UE
//    adr 13 leaves err_adr=12.
//  4 preload ce_cnt to max-1 via 2^CNT_W-2 CEs (CNT_W=4), 3 more CEs -> ce_cnt stays 15; err_clr
//    with CE same cycle -> ce_cnt=1.
//  5 reads every cycle for 64 adrs, reset asserted mid-stream 1 cycle -> no out_val for reads issued
//    before/during reset; next read outputs normally.
//  6 SCRUB_EN: CE adr 7 -> scr_req, scr_dat holds corrected encoded word until scr_ack; repeat, then
//    wr_enb adr 7 before ack -> scr_req drops next cycle.

Source files
------------

// File: rtl/ra_rd_ecc_sdr_pkg.sv
// Shared ECC definitions for the read/write-side array ECC: code widths, Hsiao (72,64) H matrix
// columns, check-bit generator and the decoder result record.
package ra_rd_ecc_sdr_pkg;

  localparam int DATA_W = 64;
  localparam int CHK_W  = 8;
  localparam int SYN_W  = CHK_W;
  localparam int CODE_W = DATA_W + CHK_W;
  localparam int ADR_W  = 6;

  typedef struct packed {
    logic [SYN_W-1:0]  syn;
    logic [DATA_W-1:0] dat;
    logic              ce;
    logic              ue;
  } dec_t;

  // Data columns: all 56 weight-3 patterns ascending, then the first 8 weight-5 patterns.
  // Check-bit columns are the unit vectors, so every column has odd weight and is unique.
  function automatic logic [DATA_W*CHK_W-1:0] gen_h_data();
    logic [DATA_W*CHK_W-1:0] h;
    int n;
    int wt;
    h = '0;
    n = 0;
    for (int w = 3; w <= 5; w += 2) begin
      for (int v = 1; v < 256; v++) begin
        wt = 0;
        for (int b = 0; b < 8; b++) wt += (v >> b) & 1;
        if (wt == w && n < DATA_W) begin
          h[n*CHK_W +: CHK_W] = CHK_W'(v);
          n++;
        end
      end
    end
    return h;
  endfunction

  localparam logic [DATA_W*CHK_W-1:0] H_DATA = gen_h_data();

  function automatic logic [CHK_W-1:0] chk_gen(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (d[i]) c = c ^ H_DATA[i*CHK_W +: CHK_W];
    end
    return c;
  endfunction

endpackage

// File: rtl/ra_ecc_dec.sv
// Combinational SECDED decoder: 72b codeword -> syndrome, corrected data, CE/UE flags.
module ra_ecc_dec
  import ra_rd_ecc_sdr_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output dec_t              dec
);

  logic [SYN_W-1:0] syn;
  logic             hit;

  always_comb begin
    syn     = chk_gen(code[DATA_W-1:0]) ^ code[CODE_W-1:DATA_W];
    hit     = $onehot(syn);
    dec.syn = syn;
    dec.dat = code[DATA_W-1:0];
    for (int i = 0; i < DATA_W; i++) begin
      if (syn == H_DATA[i*CHK_W +: CHK_W]) begin
        dec.dat[i] = ~code[i];
        hit        = 1'b1;
      end
    end
    // Any even-weight nonzero syndrome (double error) can never match an odd-weight column.
    dec.ce = hit;
    dec.ue = (syn != '0) && !hit;
  end

endmodule

// File: rtl/ra_rd_ecc_sdr.sv
// Read-port ECC stage: read-valid pipe, SECDED check/correct, error counters, first-error log.
// Define RA_ECC_SCRUB_EN to add the CE scrub-request FSM with write snoop.
module ra_rd_ecc_sdr
  import ra_rd_ecc_sdr_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ecc_en,
  input  logic              rd_enb,
  input  logic [ADR_W-1:0]  rd_adr,
  input  logic [CODE_W-1:0] rd_dat,
  output logic              out_val,
  output logic [DATA_W-1:0] out_dat,
  output logic              out_ce,
  output logic              out_ue,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  ce_cnt,
  output logic [CNT_W-1:0]  ue_cnt,
  output logic              err_vld,
  output logic [ADR_W-1:0]  err_adr,
  output logic [SYN_W-1:0]  err_syn
`ifdef RA_ECC_SCRUB_EN
  ,
  output logic              scr_req,
  output logic [ADR_W-1:0]  scr_adr,
  output logic [CODE_W-1:0] scr_dat,
  input  logic              scr_ack,
  input  logic              wr_enb,
  input  logic [ADR_W-1:0]  wr_adr
`endif
);

  localparam int LAST = RD_LAT - 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Stage p0: issued read tracked across the array latency
  logic [RD_LAT-1:0] vld_p0;
  logic [ADR_W-1:0]  adr_p0 [RD_LAT];
  dec_t              dec_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= '0;
    end else begin
      vld_p0[0] <= rd_enb;
      for (int i = 1; i < RD_LAT; i++) vld_p0[i] <= vld_p0[i-1];
    end
  end

  always_ff @(posedge clk) begin
    adr_p0[0] <= rd_adr;
    for (int i = 1; i < RD_LAT; i++) adr_p0[i] <= adr_p0[i-1];
  end

  ra_ecc_dec u_dec (
    .code (rd_dat),
    .dec  (dec_p0)
  );

  // Stage p1: registered decode result
  logic [ADR_W-1:0] adr_p1;
  logic [SYN_W-1:0] syn_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_val <= 1'b0;
      out_ce  <= 1'b0;
      out_ue  <= 1'b0;
      out_dat <= '0;
    end else begin
      out_val <= vld_p0[LAST];
      out_ce  <= vld_p0[LAST] & ecc_en & dec_p0.ce;
      out_ue  <= vld_p0[LAST] & ecc_en & dec_p0.ue;
      out_dat <= ecc_en ? dec_p0.dat : rd_dat[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    adr_p1 <= adr_p0[LAST];
    syn_p1 <= dec_p0.syn;
  end

  // Stage p2: counters and log track the registered CE/UE outputs
  logic [CNT_W-1:0] ce_base;
  logic [CNT_W-1:0] ue_base;
  logic             err_ev;
  logic             log_ue;

  assign ce_base = err_clr ? '0 : ce_cnt;
  assign ue_base = err_clr ? '0 : ue_cnt;
  assign err_ev  = out_ce | out_ue;

  always_ff @(posedge clk) begin
    if (reset) begin
      ce_cnt <= '0;
      ue_cnt <= '0;
    end else begin
      ce_cnt <= out_ce ? sat_inc(ce_base) : ce_base;
      ue_cnt <= out_ue ? sat_inc(ue_base) : ue_base;
    end
  end

  // A held CE entry may be replaced by one UE; a held UE is final until cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_vld <= 1'b0;
      log_ue  <= 1'b0;
      err_adr <= '0;
      err_syn <= '0;
    end else if (err_clr) begin
      err_vld <= err_ev;
      log_ue  <= out_ue;
      err_adr <= err_ev ? adr_p1 : '0;
      err_syn <= err_ev ? syn_p1 : '0;
    end else if (err_ev && (!err_vld || (out_ue && !log_ue))) begin
      err_vld <= 1'b1;
      log_ue  <= out_ue;
      err_adr <= adr_p1;
      err_syn <= syn_p1;
    end
  end

`ifdef RA_ECC_SCRUB_EN
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  logic [0:0] scr_st;

  always_ff @(posedge clk) begin
    if (reset) begin
      scr_st <= S_IDLE;
    end else begin
      case (scr_st)
        S_IDLE:  if (out_ce) scr_st <= S_REQ;
        default: if (scr_ack || (wr_enb && wr_adr == scr_adr)) scr_st <= S_IDLE;
      endcase
    end
  end

  // Captured only on entry to REQ, so the request payload stays stable until it retires.
  always_ff @(posedge clk) begin
    if (scr_st == S_IDLE && out_ce) begin
      scr_adr <= adr_p1;
      scr_dat <= {chk_gen(out_dat), out_dat};
    end
  end

  assign scr_req = (scr_st == S_REQ);
`endif

endmodule

// File: tb/tb_ra_rd_ecc_sdr.sv
// Bench for ra_rd_ecc_sdr (RD_LAT=1, CNT_W=4): directed vector table, saturation/clear and
// mid-stream reset sequences, then randomized traffic against a flip-count based reference model.
`timescale 1ns/1ps
module tb_ra_rd_ecc_sdr;

  localparam int RD_LAT = 1;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset, ecc_en, rd_enb, err_clr;
  logic [5:0]        rd_adr;
  logic [71:0]       rd_dat;
  logic              out_val, out_ce, out_ue, err_vld;
  logic [63:0]       out_dat;
  logic [CNT_W-1:0]  ce_cnt, ue_cnt;
  logic [5:0]        err_adr;
  logic [7:0]        err_syn;
`ifdef RA_ECC_SCRUB_EN
  logic              scr_req, scr_ack, wr_enb;
  logic [5:0]        scr_adr, wr_adr;
  logic [71:0]       scr_dat;
`endif

  always #5 clk = ~clk;

  ra_rd_ecc_sdr #(.RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ecc_en(ecc_en), .rd_enb(rd_enb), .rd_adr(rd_adr),
    .rd_dat(rd_dat), .out_val(out_val), .out_dat(out_dat), .out_ce(out_ce), .out_ue(out_ue),
    .err_clr(err_clr), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt), .err_vld(err_vld),
    .err_adr(err_adr), .err_syn(err_syn)
`ifdef RA_ECC_SCRUB_EN
    , .scr_req(scr_req), .scr_adr(scr_adr), .scr_dat(scr_dat), .scr_ack(scr_ack),
    .wr_enb(wr_enb), .wr_adr(wr_adr)
`endif
  );

  typedef struct {
    logic        v;
    logic [5:0]  adr;
    logic [63:0] data;
    logic [71:0] word;
    logic        ecc;
    int          nflip;
  } rd_t;

  typedef struct {
    logic [5:0]  adr;
    logic [63:0] data;
    int          b0, b1;
    logic        ecc;
    logic [63:0] exp_dat;
    logic        exp_ce, exp_ue;
    int          exp_cce, exp_cue;
    logic        exp_vld;
    logic [5:0]  exp_adr;
  } vec_t;

  logic [7:0]  hcol [72];
  rd_t         p1, p2, idle;
  vec_t        tbl [7];
  int          checks = 0;
  int          errors = 0;
  int          m_ce, m_ue;
  logic        m_vld, m_held_ue;
  logic [5:0]  m_adr;
  logic [7:0]  m_syn;
  logic        seen_ce, seen_ue;
  logic [63:0] seen_dat;
  int          seen_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] enc(input logic [63:0] d);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < 64; i++) if (d[i]) c ^= hcol[i];
    return c;
  endfunction

  function automatic rd_t mk(input logic v, input logic [5:0] adr, input logic [63:0] d,
                             input int b0, input int b1, input logic ecc);
    rd_t r;
    r.v = v; r.adr = adr; r.data = d; r.ecc = ecc; r.nflip = 0;
    r.word = {enc(d), d};
    if (b0 >= 0) begin r.word[b0] = ~r.word[b0]; r.nflip++; end
    if (b1 >= 0) begin r.word[b1] = ~r.word[b1]; r.nflip++; end
    return r;
  endfunction

  // One clock: check visible state against the model, advance the model, drive next inputs.
  task automatic tick(input rd_t nw, input logic clr, input logic rst);
    logic [63:0] xdat;
    logic [7:0]  xsyn;
    logic        xce, xue, ev;
    @(negedge clk);
    chk("ce_cnt", 64'(ce_cnt), 64'(m_ce));
    chk("ue_cnt", 64'(ue_cnt), 64'(m_ue));
    chk("err_vld", 64'(err_vld), 64'(m_vld));
    chk("err_adr", 64'(err_adr), 64'(m_adr));
    chk("err_syn", 64'(err_syn), 64'(m_syn));
    chk("out_val", 64'(out_val), 64'(p2.v));
    xce = 1'b0; xue = 1'b0;
    xdat = p2.word[63:0];
    xsyn = enc(p2.word[63:0]) ^ p2.word[71:64];
    if (p2.ecc && p2.nflip <= 1) xdat = p2.data;
    if (p2.ecc && p2.nflip == 1) xce = 1'b1;
    if (p2.ecc && p2.nflip == 2) xue = 1'b1;
    if (p2.v) begin
      chk("out_dat", out_dat, xdat);
      chk("out_ce", 64'(out_ce), 64'(xce));
      chk("out_ue", 64'(out_ue), 64'(xue));
      seen_ce = out_ce; seen_ue = out_ue; seen_dat = out_dat; seen_cnt++;
    end
    ev = p2.v && (xce || xue);
    if (rst) begin
      m_ce = 0; m_ue = 0; m_vld = 1'b0; m_held_ue = 1'b0; m_adr = '0; m_syn = '0;
    end else begin
      if (clr) begin m_ce = 0; m_ue = 0; end
      if (p2.v && xce) m_ce = (m_ce == CMAX) ? CMAX : m_ce + 1;
      if (p2.v && xue) m_ue = (m_ue == CMAX) ? CMAX : m_ue + 1;
      if (clr) begin
        m_vld = ev; m_held_ue = ev && xue;
        m_adr = ev ? p2.adr : 6'd0;
        m_syn = ev ? xsyn : 8'd0;
      end else if (ev && (!m_vld || (xue && !m_held_ue))) begin
        m_vld = 1'b1; m_held_ue = xue; m_adr = p2.adr; m_syn = xsyn;
      end
    end
    reset = rst; err_clr = clr;
    rd_enb = nw.v; rd_adr = nw.adr;
    rd_dat = p1.word; ecc_en = p1.ecc;
    p2 = p1; p1 = nw;
    if (rst) begin p2.v = 1'b0; p1.v = 1'b0; end
  endtask

  initial begin
    int n;
    int b0, b1, nf;
    logic [63:0] rd64;
    n = 0;
    for (int w = 3; w <= 5; w += 2)
      for (int v = 1; v < 256; v++)
        if ($countones(8'(v)) == w && n < 64) begin hcol[n] = 8'(v); n++; end
    for (int k = 0; k < 8; k++) hcol[64+k] = 8'(1 << k);

    tbl[0] = '{6'd5,  64'hA5A5_0000_FFFF_1234, -1, -1, 1'b1, 64'hA5A5_0000_FFFF_1234,
               1'b0, 1'b0, 0, 0, 1'b0, 6'd0};
    tbl[1] = '{6'd9,  64'hDEAD_BEEF_CAFE_F00D, 17, -1, 1'b1, 64'hDEAD_BEEF_CAFE_F00D,
               1'b1, 1'b0, 1, 0, 1'b1, 6'd9};
    tbl[2] = '{6'd12, 64'h0123_4567_89AB_CDEF, 3, 40, 1'b1, 64'h0123_4467_89AB_CDE7,
               1'b0, 1'b1, 1, 1, 1'b1, 6'd12};
    tbl[3] = '{6'd13, 64'hFFFF_FFFF_FFFF_FFFF, 0, 63, 1'b1, 64'h7FFF_FFFF_FFFF_FFFE,
               1'b0, 1'b1, 1, 2, 1'b1, 6'd12};
    tbl[4] = '{6'd20, 64'h1111_2222_3333_4444, 66, -1, 1'b1, 64'h1111_2222_3333_4444,
               1'b1, 1'b0, 2, 2, 1'b1, 6'd12};
    tbl[5] = '{6'd21, 64'h5555_AAAA_5555_AAAA, 5, -1, 1'b0, 64'h5555_AAAA_5555_AA8A,
               1'b0, 1'b0, 2, 2, 1'b1, 6'd12};
    tbl[6] = '{6'd22, 64'h0F0F_0F0F_F0F0_F0F0, 64, 65, 1'b1, 64'h0F0F_0F0F_F0F0_F0F0,
               1'b0, 1'b1, 2, 3, 1'b1, 6'd12};

    idle = mk(1'b0, 6'd0, 64'd0, -1, -1, 1'b1);
    p1 = idle; p2 = idle;
    m_ce = 0; m_ue = 0; m_vld = 1'b0; m_held_ue = 1'b0; m_adr = '0; m_syn = '0;
    seen_cnt = 0; seen_ce = 1'b0; seen_ue = 1'b0; seen_dat = '0;
    reset = 1'b1; err_clr = 1'b0; rd_enb = 1'b0; rd_adr = '0; rd_dat = '0; ecc_en = 1'b1;
`ifdef RA_ECC_SCRUB_EN
    scr_ack = 1'b0; wr_enb = 1'b0; wr_adr = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_out_val", 64'(out_val), 64'd0);
    chk("rst_out_ce", 64'(out_ce), 64'd0);
    chk("rst_out_ue", 64'(out_ue), 64'd0);
    chk("rst_out_dat", out_dat, 64'd0);
    chk("rst_ce_cnt", 64'(ce_cnt), 64'd0);
    chk("rst_ue_cnt", 64'(ue_cnt), 64'd0);
    chk("rst_err_vld", 64'(err_vld), 64'd0);
    chk("rst_err_adr", 64'(err_adr), 64'd0);
    chk("rst_err_syn", 64'(err_syn), 64'd0);
`ifdef RA_ECC_SCRUB_EN
    chk("rst_scr_req", 64'(scr_req), 64'd0);
`endif

    // Directed vectors, one isolated read each
    for (int i = 0; i < 7; i++) begin
      tick(mk(1'b1, tbl[i].adr, tbl[i].data, tbl[i].b0, tbl[i].b1, tbl[i].ecc), 1'b0, 1'b0);
      repeat (3) tick(idle, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_seen", i), 64'(seen_cnt), 64'(i + 1));
      chk($sformatf("tbl%0d_dat", i), seen_dat, tbl[i].exp_dat);
      chk($sformatf("tbl%0d_ce", i), 64'(seen_ce), 64'(tbl[i].exp_ce));
      chk($sformatf("tbl%0d_ue", i), 64'(seen_ue), 64'(tbl[i].exp_ue));
      chk($sformatf("tbl%0d_ce_cnt", i), 64'(ce_cnt), 64'(tbl[i].exp_cce));
      chk($sformatf("tbl%0d_ue_cnt", i), 64'(ue_cnt), 64'(tbl[i].exp_cue));
      chk($sformatf("tbl%0d_err_vld", i), 64'(err_vld), 64'(tbl[i].exp_vld));
      chk($sformatf("tbl%0d_err_adr", i), 64'(err_adr), 64'(tbl[i].exp_adr));
    end

    // CE counter saturation, then clear coincident with a CE
    tick(idle, 1'b1, 1'b0);
    for (int i = 0; i < CMAX - 1; i++)
      tick(mk(1'b1, 6'(i), {$urandom, $urandom}, int'($urandom_range(0, 71)), -1, 1'b1), 1'b0, 1'b0);
    repeat (3) tick(idle, 1'b0, 1'b0);
    chk("sat_premax", 64'(ce_cnt), 64'(CMAX - 1));
    for (int i = 0; i < 3; i++)
      tick(mk(1'b1, 6'(40 + i), {$urandom, $urandom}, int'($urandom_range(0, 63)), -1, 1'b1), 1'b0, 1'b0);
    repeat (3) tick(idle, 1'b0, 1'b0);
    chk("sat_hold", 64'(ce_cnt), 64'(CMAX));
    tick(mk(1'b1, 6'd33, 64'h0BAD_F00D_0000_0001, 30, -1, 1'b1), 1'b0, 1'b0);
    tick(idle, 1'b0, 1'b0);
    tick(idle, 1'b1, 1'b0);
    tick(idle, 1'b0, 1'b0);
    chk("clr_ev_ce_cnt", 64'(ce_cnt), 64'd1);
    chk("clr_ev_ue_cnt", 64'(ue_cnt), 64'd0);
    chk("clr_ev_err_adr", 64'(err_adr), 64'd33);

    // Reads every cycle over all addresses with a one-cycle reset mid-stream
    seen_cnt = 0;
    for (int i = 0; i < 64; i++)
      tick(mk(1'b1, 6'(i), {$urandom, $urandom}, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 71)) : -1,
              -1, 1'b1), 1'b0, i == 30);
    repeat (3) tick(idle, 1'b0, 1'b0);
    chk("rst_stream_outputs", 64'(seen_cnt), 64'd62);

`ifdef RA_ECC_SCRUB_EN
    tick(mk(1'b1, 6'd7, 64'h1234_5678_9ABC_DEF0, 11, -1, 1'b1), 1'b0, 1'b0);
    repeat (3) tick(idle, 1'b0, 1'b0);
    chk("scr_req_set", 64'(scr_req), 64'd1);
    chk("scr_adr", 64'(scr_adr), 64'd7);
    chk("scr_dat_chk", 64'(scr_dat[71:64]), 64'(enc(64'h1234_5678_9ABC_DEF0)));
    chk("scr_dat_data", scr_dat[63:0], 64'h1234_5678_9ABC_DEF0);
    repeat (2) tick(idle, 1'b0, 1'b0);
    chk("scr_req_hold", 64'(scr_req), 64'd1);
    chk("scr_dat_hold", scr_dat[63:0], 64'h1234_5678_9ABC_DEF0);
    scr_ack = 1'b1;
    tick(idle, 1'b0, 1'b0);
    scr_ack = 1'b0;
    chk("scr_req_ack", 64'(scr_req), 64'd0);
    tick(mk(1'b1, 6'd7, 64'h0000_FFFF_0000_FFFF, 2, -1, 1'b1), 1'b0, 1'b0);
    repeat (3) tick(idle, 1'b0, 1'b0);
    chk("scr_req_again", 64'(scr_req), 64'd1);
    wr_enb = 1'b1; wr_adr = 6'd8;
    tick(idle, 1'b0, 1'b0);
    chk("scr_snoop_other", 64'(scr_req), 64'd1);
    wr_adr = 6'd7;
    tick(idle, 1'b0, 1'b0);
    wr_enb = 1'b0;
    chk("scr_snoop_cancel", 64'(scr_req), 64'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      nf = int'($urandom_range(0, 2));
      b0 = int'($urandom_range(0, 71));
      b1 = (b0 + 1 + int'($urandom_range(0, 70))) % 72;
      rd64 = {$urandom, $urandom};
      tick(mk($urandom_range(0, 3) != 0, 6'($urandom), rd64, (nf >= 1) ? b0 : -1,
              (nf == 2) ? b1 : -1, $urandom_range(0, 7) != 0),
           $urandom_range(0, 15) == 0, $urandom_range(0, 96) == 0);
    end
    repeat (3) tick(idle, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
